// File: rtl/logic_op_stream.sv
// logic_op_stream
//   Registered, streaming bitwise-op unit. It applies AND/OR/XOR/NOR to WIDTH-bit
//   operand pairs. In single-shot mode it produces one result per accepted beat.
//   In accumulate mode it folds a burst of beats into one result.
//   Both sides use a valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (!out_valid || out_ready)
//   in_a/in_b  operands, WIDTH bits
//   in_op      00 AND, 01 OR, 10 XOR, 11 NOR
//   in_acc     1 = accumulate burst, 0 = single-shot
//   in_last    last beat of an accumulate burst
//   out_valid  result valid
//   out_ready  consumer takes result
//   out_y      result, WIDTH bits
//   out_beats  beats folded into out_y, saturating at 2^CNT_W-1
//   out_zero   registered (out_y == 0)
module logic_op_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_zero
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {IDLE, ACC} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic              r_outValid;
    logic [WIDTH-1:0]  r_outY;
    logic [CNT_W-1:0]  r_outBeats;
    logic              r_outZero;

    logic              w_accept;
    logic [1:0]        w_opSel;
    logic [WIDTH-1:0]  w_beatVal;
    logic [WIDTH-1:0]  w_accNext;
    logic [CNT_W-1:0]  w_cntNext;
    logic [WIDTH-1:0]  w_result;
    logic              w_emit;

    // NOR is folded as OR; the inversion is applied once to the final result,
    // which makes a NOR burst equal to NOR over all operands.
    function automatic logic [WIDTH-1:0] foldOp(input logic [1:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (op)
            OP_AND:  foldOp = x & y;
            OP_OR:   foldOp = x | y;
            OP_XOR:  foldOp = x ^ y;
            default: foldOp = x | y;
        endcase
    endfunction

    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Inside a burst the locked op is used, so in_op is ignored in ACC.
    assign w_opSel   = (r_state == ACC) ? r_op : in_op;
    assign w_beatVal = foldOp(w_opSel, in_a, in_b);
    assign w_accNext = (r_state == ACC) ? foldOp(r_op, r_acc, w_beatVal) : w_beatVal;
    assign w_cntNext = (r_state == ACC)
                     ? ((r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1))
                     : CNT_W'(1);

    // A single-shot result goes down the same path as a one-beat burst.
    assign w_result = (w_opSel == OP_NOR) ? ~w_accNext : w_accNext;
    assign w_emit   = w_accept && ((r_state == ACC) ? in_last : (!in_acc || in_last));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_op       <= OP_AND;
            r_outValid <= 1'b0;
            r_outY     <= '0;
            r_outBeats <= '0;
            r_outZero  <= 1'b0;
        end else begin
            if (w_emit) begin
                r_outValid <= 1'b1;
                r_outY     <= w_result;
                r_outBeats <= w_cntNext;
                r_outZero  <= (w_result == '0);
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end

            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (in_acc) begin
                            r_op  <= in_op;
                            r_acc <= w_accNext;
                            r_cnt <= w_cntNext;
                            if (!in_last) begin
                                r_state <= ACC;
                            end
                        end
                    end
                    ACC: begin
                        r_acc <= w_accNext;
                        r_cnt <= w_cntNext;
                        if (in_last) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_y     = r_outY;
    assign out_beats = r_outBeats;
    assign out_zero  = r_outZero;

endmodule

// File: tb/tb_logic_op_stream.sv
// tb_logic_op_stream
//   Directed bench for logic_op_stream. It runs a table of single-shot vectors
//   and then hand-written burst, backpressure and reset sequences. A second
//   instance with CNT_W=2 shares the inputs and exposes beat-count saturation.
module tb_logic_op_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic       in_acc;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [7:0] out_beats;
    logic       out_zero;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_y2;
    logic [1:0] out_beats2;
    logic       out_zero2;

    int checkCount = 0;
    int passCount  = 0;

    logic_op_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_beats(out_beats), .out_zero(out_zero)
    );

    logic_op_stream #(.WIDTH(8), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_y(out_y2), .out_beats(out_beats2), .out_zero(out_zero2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       zero;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one beat starting at a negedge and returns on the next negedge,
    // with in_valid dropped again.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic acc,
                                 input logic last);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // T1, then a bit0 truth table over all ops, then a zero result
        vecs[0]  = '{2'b01, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[1]  = '{2'b00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{2'b00, 8'h00, 8'h01, 8'h00, 1'b1};
        vecs[3]  = '{2'b00, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{2'b00, 8'h01, 8'h01, 8'h01, 1'b0};
        vecs[5]  = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{2'b01, 8'h00, 8'h01, 8'h01, 1'b0};
        vecs[7]  = '{2'b01, 8'h01, 8'h00, 8'h01, 1'b0};
        vecs[8]  = '{2'b01, 8'h01, 8'h01, 8'h01, 1'b0};
        vecs[9]  = '{2'b10, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{2'b10, 8'h00, 8'h01, 8'h01, 1'b0};
        vecs[11] = '{2'b10, 8'h01, 8'h00, 8'h01, 1'b0};
        vecs[12] = '{2'b10, 8'h01, 8'h01, 8'h00, 1'b1};
        vecs[13] = '{2'b11, 8'h00, 8'h00, 8'hFF, 1'b0};
        vecs[14] = '{2'b11, 8'h00, 8'h01, 8'hFE, 1'b0};
        vecs[15] = '{2'b11, 8'h01, 8'h00, 8'hFE, 1'b0};
        vecs[16] = '{2'b11, 8'h01, 8'h01, 8'hFE, 1'b0};
        vecs[17] = '{2'b00, 8'hA5, 8'h5A, 8'h00, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset out_y",     32'(out_y),     32'h0);
        checkOutput("reset out_beats", 32'(out_beats), 32'h0);
        checkOutput("reset out_zero",  32'(out_zero),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-shot table; in_last is toggled to show it is ignored here
        for (int i = 0; i < 18; i++) begin
            checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'h1);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'(i % 2));
            checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
            checkOutput($sformatf("v%0d out_y", i), 32'(out_y), 32'(vecs[i].y));
            checkOutput($sformatf("v%0d out_beats", i), 32'(out_beats), 32'h1);
            checkOutput($sformatf("v%0d out_zero", i), 32'(out_zero), 32'(vecs[i].zero));
        end
        @(negedge clk);
        checkOutput("pop out_valid", 32'(out_valid), 32'h0);

        // T3: OR burst, no result until the last beat
        applyStimulus(2'b01, 8'h01, 8'h00, 1'b1, 1'b0);
        checkOutput("T3 beat1 out_valid", 32'(out_valid), 32'h0);
        applyStimulus(2'b01, 8'h02, 8'h00, 1'b1, 1'b0);
        checkOutput("T3 beat2 out_valid", 32'(out_valid), 32'h0);
        applyStimulus(2'b01, 8'h80, 8'h00, 1'b1, 1'b1);
        checkOutput("T3 out_valid", 32'(out_valid), 32'h1);
        checkOutput("T3 out_y",     32'(out_y),     32'h83);
        checkOutput("T3 out_beats", 32'(out_beats), 32'h3);

        // T4: stall with a pending input, then back-to-back results
        out_ready = 1'b0;
        in_op = 2'b00; in_a = 8'hFF; in_b = 8'h3C; in_acc = 1'b0; in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("T4 stall%0d in_ready", i), 32'(in_ready), 32'h0);
            checkOutput($sformatf("T4 stall%0d out_valid", i), 32'(out_valid), 32'h1);
            checkOutput($sformatf("T4 stall%0d out_y", i), 32'(out_y), 32'h83);
            checkOutput($sformatf("T4 stall%0d out_beats", i), 32'(out_beats), 32'h3);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("T4 first out_valid", 32'(out_valid), 32'h1);
        checkOutput("T4 first out_y",     32'(out_y),     32'h3C);
        checkOutput("T4 first out_beats", 32'(out_beats), 32'h1);
        in_op = 2'b10; in_a = 8'hAA; in_b = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("T4 second out_valid", 32'(out_valid), 32'h1);
        checkOutput("T4 second out_y",     32'(out_y),     32'h55);
        @(negedge clk);
        checkOutput("T4 drain out_valid", 32'(out_valid), 32'h0);

        // T5: reset in mid-burst discards it; a fresh one-beat burst follows
        applyStimulus(2'b01, 8'h11, 8'h00, 1'b1, 1'b0);
        applyStimulus(2'b01, 8'h22, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("T5 rst out_valid", 32'(out_valid), 32'h0);
        checkOutput("T5 rst out_y",     32'(out_y),     32'h0);
        checkOutput("T5 rst out_beats", 32'(out_beats), 32'h0);
        checkOutput("T5 rst out_zero",  32'(out_zero),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(2'b00, 8'hFF, 8'h0F, 1'b1, 1'b1);
        checkOutput("T5 out_valid", 32'(out_valid), 32'h1);
        checkOutput("T5 out_y",     32'(out_y),     32'h0F);
        checkOutput("T5 out_beats", 32'(out_beats), 32'h1);
        @(negedge clk);

        // NOR burst; the second beat's op/acc must be ignored
        applyStimulus(2'b11, 8'h01, 8'h00, 1'b1, 1'b0);
        applyStimulus(2'b00, 8'h02, 8'h00, 1'b0, 1'b1);
        checkOutput("NOR out_y",     32'(out_y),     32'hFC);
        checkOutput("NOR out_beats", 32'(out_beats), 32'h2);
        checkOutput("NOR out_zero",  32'(out_zero),  32'h0);
        @(negedge clk);

        // T6: five-beat XOR burst; CNT_W=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b10, 8'h01, 8'h00, 1'b1, 1'(i == 4));
        end
        checkOutput("T6 out_y",         32'(out_y),      32'h01);
        checkOutput("T6 out_beats",     32'(out_beats),  32'h5);
        checkOutput("T6 sat out_valid", 32'(out_valid2), 32'h1);
        checkOutput("T6 sat out_y",     32'(out_y2),     32'h01);
        checkOutput("T6 sat out_beats", 32'(out_beats2), 32'h3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
